// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word reads and buffers the returned
// {pc, instr} pairs in a small prefetch queue; a redirect flushes and refetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          push;
  logic          pop;

  // Request is suppressed during a redirect so a late ack cannot enqueue stale data.
  assign mem_req     = !rst && (count_reg < FULL) && !redirect;
  assign mem_addr    = fetch_pc_reg;
  assign push        = mem_req && mem_ack;
  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid && instr_ready && !redirect;

  // Empty queue presents zero data and the pending fetch address.
  assign instr    = instr_valid ? instr_mem[rd_ptr_reg] : 32'h0;
  assign instr_pc = instr_valid ? pc_mem[rd_ptr_reg] : fetch_pc_reg;

  always_comb begin
    count_next = count_reg;
    if (redirect) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg <= START_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else if (redirect) begin
      fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (push) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
        wr_ptr_reg   <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
      instr_mem[wr_ptr_reg] <= mem_rdata;
    end
  end

endmodule
